// File: rtl/bus_pkg.sv
// Shared definitions for the bus address decoder: FSM encoding, default slave windows
// and helpers that size the index and wait counter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DMEM_BASE  = 32'h1000_0000;
  localparam logic [31:0] DMEM_MASK  = 32'hF000_0000;
  localparam logic [31:0] TBMAN_BASE = 32'h8000_F000;
  localparam logic [31:0] TBMAN_MASK = 32'hFFFF_F000;
  localparam logic [31:0] TIMER_BASE = 32'h8000_1000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_F000;

  localparam int TIMEOUT_DEF = 15;

  // Counter only has to reach TIMEOUT-1.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_match.sv
// Combinational window match: flags a hit and returns the lowest matching slave index.
module bus_addr_match #(
  parameter int NUM_SLV = 3,
  parameter int ADDR_W  = 32,
  parameter int IDX_W   = 2
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic [NUM_SLV*ADDR_W-1:0] base,
  input  logic [NUM_SLV*ADDR_W-1:0] mask,
  output logic                      hit,
  output logic [IDX_W-1:0]          idx
);

  logic [NUM_SLV-1:0] hit_vec;

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_cmp
    assign hit_vec[gi] = ((addr & mask[gi*ADDR_W +: ADDR_W]) ==
                          (base[gi*ADDR_W +: ADDR_W] & mask[gi*ADDR_W +: ADDR_W]));
  end

  assign hit = |hit_vec;

  // Scan downwards so the lowest index overwrites any higher overlapping window.
  always_comb begin
    idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (hit_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bus_addr_decoder.sv
// Parametrised data-bus decoder with registered active-low chip selects and timeout/miss errors.
// Define BUS_ADDR_DECODER_ERRLOG_EN to add the err_addr / err_cnt error log outputs.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int                          NUM_SLV  = 3,
  parameter int                          ADDR_W   = 32,
  parameter int                          DATA_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = {TIMER_BASE, TBMAN_BASE, DMEM_BASE},
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = {TIMER_MASK, TBMAN_MASK, DMEM_MASK},
  parameter int                          TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m_req,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic                      m_we,
  input  logic [DATA_W-1:0]         m_wdata,
  input  logic [DATA_W/8-1:0]       m_wstrb,
  output logic                      m_ready,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_err,
`ifdef BUS_ADDR_DECODER_ERRLOG_EN
  output logic [ADDR_W-1:0]         err_addr,
  output logic [7:0]                err_cnt,
`endif
  output logic [NUM_SLV-1:0]        s_cs_n,
  output logic [ADDR_W-1:0]         s_addr,
  output logic                      s_we,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [DATA_W/8-1:0]       s_wstrb,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]        s_ready
);

  localparam int IDX_W  = idx_width(NUM_SLV);
  localparam int CNT_W  = cnt_width(TIMEOUT);
  localparam int STRB_W = DATA_W / 8;

  state_t              state_q, state_d;
  logic [NUM_SLV-1:0]  cs_n_q, cs_n_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                m_ready_q, m_ready_d;
  logic                m_err_q, m_err_d;
  logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
`ifdef BUS_ADDR_DECODER_ERRLOG_EN
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
`endif

  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;

  bus_addr_match #(
    .NUM_SLV (NUM_SLV),
    .ADDR_W  (ADDR_W),
    .IDX_W   (IDX_W)
  ) u_match (
    .addr (m_addr),
    .base (SLV_BASE),
    .mask (SLV_MASK),
    .hit  (hit),
    .idx  (hit_idx)
  );

  assign sel_ready = s_ready[sel_q];
  assign sel_rdata = s_rdata[sel_q*DATA_W +: DATA_W];

  always_comb begin
    state_d      = state_q;
    cs_n_d       = cs_n_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    m_ready_d    = 1'b0;
    m_err_d      = 1'b0;
    m_rdata_d    = '0;
`ifdef BUS_ADDR_DECODER_ERRLOG_EN
    err_addr_d   = err_addr_q;
    err_cnt_d    = err_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (m_req) begin
          addr_d  = m_addr;
          we_d    = m_we;
          wdata_d = m_wdata;
          wstrb_d = m_wstrb;
          sel_d   = hit_idx;
          cnt_d   = '0;
          if (hit) begin
            cs_n_d  = ~(NUM_SLV'(1) << hit_idx);
            state_d = ACCESS;
          end else begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = RESP;
          end
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A ready in the final wait cycle still completes cleanly.
        if (sel_ready) begin
          resp_rdata_d = we_q ? '0 : sel_rdata;
          resp_err_d   = 1'b0;
          cs_n_d       = '1;
          state_d      = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
          cs_n_d       = '1;
          state_d      = RESP;
        end
      end

      RESP: begin
        m_ready_d = 1'b1;
        m_err_d   = resp_err_q;
        m_rdata_d = resp_rdata_q;
        cnt_d     = '0;
        state_d   = IDLE;
`ifdef BUS_ADDR_DECODER_ERRLOG_EN
        if (resp_err_q) begin
          err_addr_d = addr_q;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
`endif
      end

      default: begin
        cs_n_d  = '1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cs_n_q       <= '1;
      cnt_q        <= '0;
      sel_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      m_ready_q    <= 1'b0;
      m_err_q      <= 1'b0;
      m_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cs_n_q       <= cs_n_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      m_ready_q    <= m_ready_d;
      m_err_q      <= m_err_d;
      m_rdata_q    <= m_rdata_d;
    end
  end

`ifdef BUS_ADDR_DECODER_ERRLOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;
`endif

  assign s_cs_n  = cs_n_q;
  assign s_addr  = addr_q;
  assign s_we    = we_q;
  assign s_wdata = wdata_q;
  assign s_wstrb = wstrb_q;
  assign m_ready = m_ready_q;
  assign m_err   = m_err_q;
  assign m_rdata = m_rdata_q;

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed self-checking bench for bus_addr_decoder; outputs are sampled on the falling edge.
module tb_bus_addr_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [2:0]  s_cs_n;
  logic [31:0] s_addr;
  logic        s_we;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [95:0] s_rdata;
  logic [2:0]  s_ready;
`ifdef BUS_ADDR_DECODER_ERRLOG_EN
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_addr_decoder dut (
    .clk     (clk),
    .reset   (reset),
    .m_req   (m_req),
    .m_addr  (m_addr),
    .m_we    (m_we),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .m_err   (m_err),
`ifdef BUS_ADDR_DECODER_ERRLOG_EN
    .err_addr(err_addr),
    .err_cnt (err_cnt),
`endif
    .s_cs_n  (s_cs_n),
    .s_addr  (s_addr),
    .s_we    (s_we),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata),
    .s_ready (s_ready)
  );

  // Present a request for exactly one rising edge, returning just after the following falling edge.
  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] ws);
    m_req = 1'b1; m_addr = a; m_we = we; m_wdata = wd; m_wstrb = ws;
    @(posedge clk);
    @(negedge clk);
    m_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    m_req = 0; m_addr = 0; m_we = 0; m_wdata = 0; m_wstrb = 0;
    s_rdata = '0; s_ready = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (s_cs_n !== 3'b111) begin n_bad++; $display("FAIL reset_cs: got %b expected 111", s_cs_n); end
    n_cmp++; if (m_ready !== 1'b0) begin n_bad++; $display("FAIL reset_m_ready: got %b expected 0", m_ready); end
    n_cmp++; if (m_err !== 1'b0) begin n_bad++; $display("FAIL reset_m_err: got %b expected 0", m_err); end
    n_cmp++; if (m_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_m_rdata: got %h expected 0", m_rdata); end
    n_cmp++; if (s_addr !== 32'h0 || s_we !== 1'b0 || s_wdata !== 32'h0 || s_wstrb !== 4'h0) begin
      n_bad++; $display("FAIL reset_s_bus: got addr %h we %b wdata %h wstrb %h expected all 0", s_addr, s_we, s_wdata, s_wstrb);
    end
`ifdef BUS_ADDR_DECODER_ERRLOG_EN
    n_cmp++; if (err_addr !== 32'h0 || err_cnt !== 8'h0) begin
      n_bad++; $display("FAIL reset_errlog: got %h/%0d expected 0/0", err_addr, err_cnt);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
    $display("txn reset done");
  endtask

  task automatic test_read;
    issue(32'h1000_0040, 1'b0, 32'h0, 4'h0);
    n_cmp++; if (s_cs_n !== 3'b110) begin n_bad++; $display("FAIL read_cs: got %b expected 110", s_cs_n); end
    n_cmp++; if (s_addr !== 32'h1000_0040) begin n_bad++; $display("FAIL read_s_addr: got %h expected 10000040", s_addr); end
    s_rdata[31:0] = 32'hDEAD_BEEF; s_ready = 3'b001;
    @(negedge clk);
    s_ready = 3'b000;
    n_cmp++; if (s_cs_n !== 3'b111 || m_ready !== 1'b0) begin
      n_bad++; $display("FAIL read_resp_state: got cs %b m_ready %b expected 111 0", s_cs_n, m_ready);
    end
    @(negedge clk);
    n_cmp++; if (m_ready !== 1'b1) begin n_bad++; $display("FAIL read_latency: got m_ready %b expected 1", m_ready); end
    n_cmp++; if (m_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL read_rdata: got %h expected deadbeef", m_rdata); end
    n_cmp++; if (m_err !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b expected 0", m_err); end
    $display("txn read  addr 10000040 rdata %h err %b", m_rdata, m_err);
    @(negedge clk);
    n_cmp++; if (m_ready !== 1'b0) begin n_bad++; $display("FAIL read_pulse_width: got m_ready %b expected 0", m_ready); end
  endtask

  task automatic test_write;
    s_rdata[63:32] = 32'h1234_5678;
    issue(32'h8000_F004, 1'b1, 32'h0000_0001, 4'hF);
    n_cmp++; if (s_cs_n !== 3'b101) begin n_bad++; $display("FAIL write_cs: got %b expected 101", s_cs_n); end
    n_cmp++; if (s_we !== 1'b1 || s_wdata !== 32'h1 || s_wstrb !== 4'hF) begin
      n_bad++; $display("FAIL write_s_bus: got we %b wdata %h wstrb %h expected 1 00000001 f", s_we, s_wdata, s_wstrb);
    end
    s_ready = 3'b010;
    @(negedge clk);
    s_ready = 3'b000;
    @(negedge clk);
    n_cmp++; if (m_ready !== 1'b1 || m_err !== 1'b0) begin
      n_bad++; $display("FAIL write_resp: got m_ready %b m_err %b expected 1 0", m_ready, m_err);
    end
    n_cmp++; if (m_rdata !== 32'h0) begin n_bad++; $display("FAIL write_rdata: got %h expected 0", m_rdata); end
    $display("txn write addr 8000f004 err %b", m_err);
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    s_ready = 3'b011;  // other slaves ready must not complete the access
    issue(32'h8000_1008, 1'b0, 32'h0, 4'h0);
    n = 0;
    while (s_cs_n === 3'b011 && n < 40) begin
      n++;
      @(negedge clk);
    end
    s_ready = 3'b000;
    n_cmp++; if (n !== 15) begin n_bad++; $display("FAIL timeout_cs_cycles: got %0d expected 15", n); end
    n_cmp++; if (m_ready !== 1'b0 || s_cs_n !== 3'b111) begin
      n_bad++; $display("FAIL timeout_resp_state: got m_ready %b cs %b expected 0 111", m_ready, s_cs_n);
    end
    @(negedge clk);
    n_cmp++; if (m_ready !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'h0) begin
      n_bad++; $display("FAIL timeout_resp: got ready %b err %b rdata %h expected 1 1 0", m_ready, m_err, m_rdata);
    end
`ifdef BUS_ADDR_DECODER_ERRLOG_EN
    n_cmp++; if (err_addr !== 32'h8000_1008 || err_cnt !== 8'd1) begin
      n_bad++; $display("FAIL timeout_errlog: got %h/%0d expected 80001008/1", err_addr, err_cnt);
    end
`endif
    $display("txn read  addr 80001008 timeout err %b", m_err);
    @(negedge clk);
  endtask

  task automatic test_unmapped;
    issue(32'h2000_0000, 1'b0, 32'h0, 4'h0);
    n_cmp++; if (s_cs_n !== 3'b111 || m_ready !== 1'b0) begin
      n_bad++; $display("FAIL unmapped_cs: got cs %b ready %b expected 111 0", s_cs_n, m_ready);
    end
    @(negedge clk);
    n_cmp++; if (m_ready !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'h0) begin
      n_bad++; $display("FAIL unmapped_resp: got ready %b err %b rdata %h expected 1 1 0", m_ready, m_err, m_rdata);
    end
`ifdef BUS_ADDR_DECODER_ERRLOG_EN
    n_cmp++; if (err_addr !== 32'h2000_0000 || err_cnt !== 8'd2) begin
      n_bad++; $display("FAIL unmapped_errlog: got %h/%0d expected 20000000/2", err_addr, err_cnt);
    end
`endif
    $display("txn read  addr 20000000 unmapped err %b", m_err);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    logic [2:0]  cs_exp [3];
    int pulses;
    addrs[0] = 32'h1000_0100; addrs[1] = 32'h8000_F010; addrs[2] = 32'h8000_1020;
    datas[0] = 32'hA0A0_0000; datas[1] = 32'hB1B1_1111; datas[2] = 32'hC2C2_2222;
    cs_exp[0] = 3'b110; cs_exp[1] = 3'b101; cs_exp[2] = 3'b011;
    s_rdata = {datas[2], datas[1], datas[0]};
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      m_req = 1'b1; m_addr = addrs[k]; m_we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (m_ready === 1'b1) pulses++;
      n_cmp++; if (s_cs_n !== cs_exp[k]) begin n_bad++; $display("FAIL b2b_cs%0d: got %b expected %b", k, s_cs_n, cs_exp[k]); end
      s_ready = ~s_cs_n;
      // keep m_req high with the next address while the access is in flight
      m_addr = addrs[(k + 1) % 3];
      m_req  = (k < 2);
      @(negedge clk);
      s_ready = 3'b000;
      if (m_ready === 1'b1) pulses++;
      n_cmp++; if (s_addr !== addrs[k] || s_cs_n !== 3'b111) begin
        n_bad++; $display("FAIL b2b_hold%0d: got addr %h cs %b expected %h 111", k, s_addr, s_cs_n, addrs[k]);
      end
      @(negedge clk);
      if (m_ready === 1'b1) pulses++;
      n_cmp++; if (m_ready !== 1'b1 || m_rdata !== datas[k] || m_err !== 1'b0) begin
        n_bad++; $display("FAIL b2b_resp%0d: got ready %b rdata %h err %b expected 1 %h 0", k, m_ready, m_rdata, m_err, datas[k]);
      end
      $display("txn b2b   addr %h rdata %h", addrs[k], m_rdata);
    end
    m_req = 1'b0;
    @(negedge clk);
    if (m_ready === 1'b1) pulses++;
    n_cmp++; if (pulses !== 3) begin n_bad++; $display("FAIL b2b_pulse_count: got %0d expected 3", pulses); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    issue(32'h8000_F000, 1'b0, 32'h0, 4'h0);
    n_cmp++; if (s_cs_n !== 3'b101) begin n_bad++; $display("FAIL rst_mid_cs_before: got %b expected 101", s_cs_n); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (s_cs_n !== 3'b111) begin n_bad++; $display("FAIL rst_mid_cs_release: got %b expected 111", s_cs_n); end
    s_ready = 3'b010;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_ready === 1'b1) pulses++;
    end
    s_ready = 3'b000;
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rst_mid_dropped: got %0d m_ready pulses expected 0", pulses); end
    s_rdata[31:0] = 32'h5555_AAAA;
    issue(32'h1FFF_FFFC, 1'b0, 32'h0, 4'h0);
    n_cmp++; if (s_cs_n !== 3'b110) begin n_bad++; $display("FAIL rst_mid_next_cs: got %b expected 110", s_cs_n); end
    s_ready = 3'b001;
    @(negedge clk);
    s_ready = 3'b000;
    @(negedge clk);
    n_cmp++; if (m_ready !== 1'b1 || m_rdata !== 32'h5555_AAAA || m_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_next_resp: got ready %b rdata %h err %b expected 1 5555aaaa 0", m_ready, m_rdata, m_err);
    end
    $display("txn read  addr 1ffffffc after reset rdata %h", m_rdata);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_addr_decoder.md
Name: bus_addr_decoder

Overview:
Parametrised successor to the fixed two-target chip-select decoder. Sits between the core's data-memory port and NUM_SLV targets (dmem, tbman, timer, ...). Decodes each request against per-slave base/mask windows and drives registered active-low chip selects. Sequences the access with a small FSM, then returns read data or an error on an unmapped address or a slave timeout.

Parameters:
NUM_SLV, 3, number of target slaves
ADDR_W, 32, address width
DATA_W, 32, data width
SLV_BASE, {32'h8000_1000, 32'h8000_F000, 32'h1000_0000}, packed NUM_SLV*ADDR_W bases; slave i uses slice i
SLV_MASK, {32'hFFFF_F000, 32'hFFFF_F000, 32'hF000_0000}, packed compare masks; slave i uses slice i
TIMEOUT, 15, max wait cycles for s_ready, >=1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
m_req  in  1  master request strobe, sampled only in IDLE
m_addr  in  ADDR_W  request address
m_we  in  1  1=write, 0=read
m_wdata  in  DATA_W  write data
m_wstrb  in  DATA_W/8  byte enables
m_ready  out  1  one-cycle completion pulse
m_rdata  out  DATA_W  read data, valid while m_ready=1
m_err  out  1  error flag, valid while m_ready=1
s_cs_n  out  NUM_SLV  per-slave active-low chip select
s_addr  out  ADDR_W  latched address
s_we  out  1  latched write enable
s_wdata  out  DATA_W  latched write data
s_wstrb  out  DATA_W/8  latched byte enables
s_rdata  in  NUM_SLV*DATA_W  packed slave read data
s_ready  in  NUM_SLV  per-slave ready

Behaviour:
- Match rule: slave i hits when (m_addr & MASK_i) == (BASE_i & MASK_i). On overlapping windows the lowest index wins.
- Reset, asynchronous: state=IDLE, s_cs_n all 1, m_ready=0, m_err=0, m_rdata=0, s_addr/s_we/s_wdata/s_wstrb=0, wait counter=0.
- FSM states:
  - IDLE: on m_req=1, latch addr/we/wdata/wstrb and the hit index.
    - On a hit, go to ACCESS and register s_cs_n[sel]=0 in the same edge.
    - On a miss, go to RESP with err=1 and rdata=0.
    - m_req=0 keeps the FSM in IDLE.
  - ACCESS: s_cs_n[sel] held low; counter increments each cycle.
    - s_ready[sel]=1: capture the s_rdata slice (0 for writes), err=0, deassert cs, go to RESP.
    - Else if counter==TIMEOUT-1: deassert cs, err=1, rdata=0, go to RESP.
    - s_ready[sel] takes priority over timeout in the same cycle.
    - s_ready of non-selected slaves is ignored.
  - RESP: m_ready=1 for exactly one cycle, m_rdata/m_err valid; clear counter; return to IDLE.
- Latency: minimum 2 cycles, req edge to m_ready, when the slave is ready in the first ACCESS cycle. An unmapped access takes 1 cycle.
- m_req outside IDLE is ignored. Back-to-back requests: a new request is accepted in the IDLE cycle after RESP.
- At most one s_cs_n bit is low at any time; all bits high outside ACCESS.
- Reset asserted mid-ACCESS: cs released immediately; the pending transaction is dropped with no m_ready.

Optional Feature:
- Macro: BUS_ADDR_DECODER_ERRLOG_EN.
- Defined: adds outputs err_addr (ADDR_W) and err_cnt (8 bits, saturating at 255).
  - err_addr latches s_addr on every RESP with err=1.
  - err_cnt increments on each such RESP.
  - Both reset to 0.
- Undefined: neither port nor logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package bus_pkg: FSM state encoding (IDLE/ACCESS/RESP), default base/mask constants for DMEM/TBMAN/TIMER, and the counter width derived from TIMEOUT ($clog2).
- One combinational sub-module, bus_addr_match:
  - inputs: addr, BASE, MASK packed;
  - outputs: hit flag and priority-encoded index;
  - instantiated once in the top.

Test Plan:
- Read 0x1000_0040, s_ready[0] high 1 cycle after cs → s_cs_n=3'b110 for 1 cycle; m_ready on cycle 2 with m_rdata=slave0 data 0xDEAD_BEEF, m_err=0.
- Write 0x8000_F004 wdata 0x0000_0001, wstrb 4'hF → s_cs_n=3'b101; s_we=1, s_wdata=1; m_ready with m_err=0.
- Read 0x2000_0000 (unmapped) → no cs asserted; m_ready on cycle 1 with m_err=1, m_rdata=0.
- Read 0x8000_1008 with s_ready[2] never asserted → cs low for 15 cycles, then m_ready with m_err=1; with ERRLOG_EN, err_addr=0x8000_1008 and err_cnt=1.
- Three back-to-back requests to slaves 0, 1, 2 → exactly three m_ready pulses in order, never two cs bits low at once; m_req during ACCESS is ignored.
- Reset pulse during ACCESS → s_cs_n=3'b111 immediately, no m_ready; the next request completes normally.
